// File: rtl/argon_alu_mc_pkg.sv
// Shared definitions for the Argon ALU: opcodes, bus commands, flag bit indices and sequencer states.
// Used by argon_alu_mc and argon_muldiv_seq; MUL/DIVU exist only when ARGON_ALU_MULDIV_EN is defined.
package argon_alu_mc_pkg;

  typedef enum logic [4:0] {
    ALU_ADD  = 5'd0,
    ALU_ADC  = 5'd1,
    ALU_SBC  = 5'd2,
    ALU_CMP  = 5'd3,
    ALU_INC  = 5'd4,
    ALU_DEC  = 5'd5,
    ALU_NAND = 5'd6,
    ALU_AND  = 5'd7,
    ALU_OR   = 5'd8,
    ALU_NOR  = 5'd9,
    ALU_XOR  = 5'd10,
    ALU_LSH  = 5'd11,
    ALU_RSH  = 5'd12,
    ALU_ROL  = 5'd13,
    ALU_ROR  = 5'd14,
    ALU_MUL  = 5'd15,
    ALU_DIVU = 5'd16
  } op_e;

  typedef enum logic [3:0] {
    COM_NOP     = 4'd0,
    COM_LATCHA  = 4'd1,
    COM_LATCHB  = 4'd2,
    COM_LATCHF  = 4'd3,
    COM_LATCHOP = 4'd4,
    COM_COMPUTE = 4'd5,
    COM_OUTPUTY = 4'd6,
    COM_OUTPUTF = 4'd7,
    COM_OUTPUTH = 4'd8
  } com_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } state_e;

  localparam int F_CARRY   = 0;
  localparam int F_ZERO    = 1;
  localparam int F_EQUAL   = 2;
  localparam int F_GREATER = 3;
  localparam int F_LESS    = 4;
  localparam int F_ERROR   = 7;

endpackage

// File: rtl/argon_alu_mc_if.sv
// Command bus between the CPU datapath (master) and the Argon ALU (slave).
// Writes qualify on i_valid and land only while o_busy is low; reads are combinational from i_command.
interface argon_alu_mc_if #(
  parameter int WIDTH = 16
);
  logic [3:0]       i_command;
  logic             i_valid;
  logic [WIDTH-1:0] i_data;
  logic [WIDTH-1:0] o_data;
  logic             o_valid;
  logic             o_busy;
  logic [1:0]       o_dbg_state;

  modport slave (
    input  i_command, i_valid, i_data,
    output o_data, o_valid, o_busy, o_dbg_state
  );

  modport master (
    output i_command, i_valid, i_data,
    input  o_data, o_valid, o_busy, o_dbg_state
  );
endinterface

// File: rtl/argon_muldiv_seq.sv
// Iterative unsigned multiplier (shift-add) and restoring divider; one iteration per busy cycle.
// hi_o/lo_o present the post-iteration values so the owner can capture them on the done edge.
module argon_muldiv_seq
  import argon_alu_mc_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             div_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic [1:0]       state_o
);
  localparam int CW = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, opnd_q, opnd_d;
  logic [WIDTH-1:0] hi_step, lo_step;
  logic [WIDTH:0]   mul_sum, div_trial;
  logic             last;

  assign last = (state_q != ST_IDLE) && (cnt_q == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      opnd_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      opnd_q  <= opnd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start_i) state_d = div_i ? ST_DIV : ST_MUL;
      ST_MUL,
      ST_DIV:  if (last) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // {hi,lo} is the product accumulator for MUL and the {remainder,quotient} pair for DIV.
  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    div_trial = {hi_q, lo_q[WIDTH-1]} - {1'b0, opnd_q};
    hi_step   = hi_q;
    lo_step   = lo_q;
    if (state_q == ST_MUL) begin
      {hi_step, lo_step} = {mul_sum, lo_q[WIDTH-1:1]};
    end else if (state_q == ST_DIV) begin
      if (!div_trial[WIDTH]) begin
        hi_step = div_trial[WIDTH-1:0];
        lo_step = {lo_q[WIDTH-2:0], 1'b1};
      end else begin
        hi_step = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
        lo_step = {lo_q[WIDTH-2:0], 1'b0};
      end
    end
  end

  always_comb begin
    cnt_d  = cnt_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    opnd_d = opnd_q;
    if (state_q == ST_IDLE) begin
      if (start_i) begin
        cnt_d  = '0;
        hi_d   = '0;
        lo_d   = a_i;
        opnd_d = b_i;
      end
    end else begin
      cnt_d = cnt_q + CW'(1);
      hi_d  = hi_step;
      lo_d  = lo_step;
    end
  end

  always_comb begin
    busy_o  = (state_q != ST_IDLE);
    done_o  = last;
    hi_o    = hi_step;
    lo_o    = lo_step;
    state_o = state_q;
  end

endmodule

// File: rtl/argon_alu_mc.sv
// Argon ALU bus slave: register file rA/rB/rOp/rF/rY/rH, single-cycle ops and optional multi-cycle MUL/DIVU.
// Define ARGON_ALU_MULDIV_EN to build the MUL/DIVU sequencer; otherwise those opcodes report F_ERROR.
module argon_alu_mc
  import argon_alu_mc_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic          i_Clk,
  input  logic          i_Reset,
  argon_alu_mc_if.slave bus
);
  localparam int SHW = $clog2(WIDTH);

  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, y_q, y_d, h_q, h_d;
  logic [7:0]         f_q, f_d;
  op_e                op_q, op_d;
  com_e               cmd;
  logic               wr_en, compute_fire;
  logic [WIDTH-1:0]   y_res, h_res;
  logic [7:0]         f_res, md_flags;
  logic               zero_en, md_start;
  logic [WIDTH:0]     add_w;
  logic [2*WIDTH-1:0] rot_w;
  logic [SHW-1:0]     sh;
  logic               md_busy, md_done;
  logic [WIDTH-1:0]   md_hi, md_lo;
  logic [WIDTH-1:0]   rd_data;
  logic               rd_cmd;

  assign cmd          = com_e'(bus.i_command);
  assign wr_en        = bus.i_valid && !md_busy;
  assign compute_fire = wr_en && (cmd == COM_COMPUTE);
  assign sh           = b_q[SHW-1:0];

`ifdef ARGON_ALU_MULDIV_EN
  argon_muldiv_seq #(.WIDTH(WIDTH)) u_muldiv (
    .clk     (i_Clk),
    .rst     (i_Reset),
    .start_i (compute_fire && md_start),
    .div_i   (op_q == ALU_DIVU),
    .a_i     (a_q),
    .b_i     (b_q),
    .busy_o  (md_busy),
    .done_o  (md_done),
    .hi_o    (md_hi),
    .lo_o    (md_lo),
    .state_o (bus.o_dbg_state)
  );
`else
  assign md_busy         = 1'b0;
  assign md_done         = 1'b0;
  assign md_hi           = '0;
  assign md_lo           = '0;
  assign bus.o_dbg_state = ST_IDLE;
`endif

  always_comb begin
    y_res    = y_q;
    h_res    = h_q;
    f_res    = '0;
    zero_en  = 1'b1;
    md_start = 1'b0;
    add_w    = '0;
    rot_w    = '0;
    case (op_q)
      ALU_ADD: add_w = {1'b0, a_q} + {1'b0, b_q};
      ALU_ADC: add_w = {1'b0, a_q} + {1'b0, b_q} + {{WIDTH{1'b0}}, f_q[F_CARRY]};
      ALU_SBC: add_w = {1'b0, a_q} + {1'b0, ~b_q} + {{WIDTH{1'b0}}, f_q[F_CARRY]};
      ALU_INC: add_w = {1'b0, a_q} + {{WIDTH{1'b0}}, 1'b1};
      ALU_DEC: add_w = {1'b0, a_q} + {1'b0, {WIDTH{1'b1}}};
      ALU_CMP: begin
        f_res[F_EQUAL]   = (a_q == b_q);
        f_res[F_GREATER] = (a_q > b_q);
        f_res[F_LESS]    = (a_q < b_q);
      end
      ALU_NAND: y_res = ~(a_q & b_q);
      ALU_AND:  y_res = a_q & b_q;
      ALU_OR:   y_res = a_q | b_q;
      ALU_NOR:  y_res = ~(a_q | b_q);
      ALU_XOR:  y_res = a_q ^ b_q;
      ALU_LSH:  y_res = a_q << sh;
      ALU_RSH:  y_res = a_q >> sh;
      ALU_ROL: begin
        rot_w = {a_q, a_q} << sh;
        y_res = rot_w[2*WIDTH-1:WIDTH];
      end
      ALU_ROR: begin
        rot_w = {a_q, a_q} >> sh;
        y_res = rot_w[WIDTH-1:0];
      end
`ifdef ARGON_ALU_MULDIV_EN
      ALU_MUL: md_start = 1'b1;
      ALU_DIVU: begin
        // Divide-by-zero finishes immediately instead of running the sequencer.
        if (b_q == '0) begin
          y_res          = '1;
          h_res          = a_q;
          f_res[F_ERROR] = 1'b1;
          zero_en        = 1'b0;
        end else begin
          md_start = 1'b1;
        end
      end
`endif
      default: begin
        y_res          = '0;
        f_res[F_ERROR] = 1'b1;
        zero_en        = 1'b0;
      end
    endcase
    if (op_q inside {ALU_ADD, ALU_ADC, ALU_SBC, ALU_INC, ALU_DEC}) begin
      y_res          = add_w[WIDTH-1:0];
      f_res[F_CARRY] = add_w[WIDTH];
    end
    if (zero_en) f_res[F_ZERO] = (y_res == '0);
  end

  always_comb begin
    md_flags = '0;
    if (op_q == ALU_MUL) begin
      md_flags[F_CARRY] = (md_hi != '0);
      md_flags[F_ZERO]  = ({md_hi, md_lo} == '0);
    end else begin
      md_flags[F_ZERO]  = (md_lo == '0);
    end
  end

  always_comb begin
    a_d  = a_q;
    b_d  = b_q;
    y_d  = y_q;
    h_d  = h_q;
    f_d  = f_q;
    op_d = op_q;
    if (wr_en) begin
      case (cmd)
        COM_LATCHA:  a_d  = bus.i_data;
        COM_LATCHB:  b_d  = bus.i_data;
        COM_LATCHF:  f_d  = bus.i_data[7:0];
        COM_LATCHOP: op_d = op_e'(bus.i_data[4:0]);
        COM_COMPUTE: begin
          if (!md_start) begin
            y_d = y_res;
            h_d = h_res;
            f_d = f_res;
          end
        end
        default: ;
      endcase
    end
    if (md_done) begin
      y_d = md_lo;
      h_d = md_hi;
      f_d = md_flags;
    end
  end

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      a_q  <= '0;
      b_q  <= '0;
      y_q  <= '0;
      h_q  <= '0;
      f_q  <= '0;
      op_q <= ALU_ADD;
    end else begin
      a_q  <= a_d;
      b_q  <= b_d;
      y_q  <= y_d;
      h_q  <= h_d;
      f_q  <= f_d;
      op_q <= op_d;
    end
  end

  always_comb begin
    rd_data = '0;
    rd_cmd  = 1'b1;
    case (cmd)
      COM_OUTPUTY: rd_data = y_q;
      COM_OUTPUTH: rd_data = h_q;
      COM_OUTPUTF: rd_data = {{(WIDTH-8){1'b0}}, f_q};
      default:     rd_cmd  = 1'b0;
    endcase
    bus.o_busy  = md_busy;
    bus.o_valid = rd_cmd && !md_busy;
    bus.o_data  = (rd_cmd && !md_busy) ? rd_data : '0;
  end

endmodule

// File: tb/tb_argon_alu_mc.sv
// Directed bench for argon_alu_mc at WIDTH=16; MUL/DIVU vectors follow the ARGON_ALU_MULDIV_EN build.
module tb_argon_alu_mc;
  import argon_alu_mc_pkg::*;

  localparam int W = 16;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  logic [W-1:0] exp_q[$];

  argon_alu_mc_if #(.WIDTH(W)) bus ();

  argon_alu_mc #(.WIDTH(W)) dut (
    .i_Clk   (clk),
    .i_Reset (rst),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic wr(input com_e c, input logic [W-1:0] d);
    @(negedge clk);
    bus.i_command = c;
    bus.i_valid   = 1'b1;
    bus.i_data    = d;
    @(negedge clk);
    bus.i_command = COM_NOP;
    bus.i_valid   = 1'b0;
    bus.i_data    = '0;
  endtask

  task automatic run_op(input op_e op, input logic [W-1:0] a, input logic [W-1:0] b);
    wr(COM_LATCHA, a);
    wr(COM_LATCHB, b);
    wr(COM_LATCHOP, W'(op));
    wr(COM_COMPUTE, '0);
  endtask

  // Pops the next expected value and compares it against a bus read of cmd.
  task automatic rd_check(input com_e c, input string tag);
    logic [W-1:0] e;
    e = exp_q.pop_front();
    bus.i_command = c;
    bus.i_valid   = 1'b0;
    #1;
    check(tag, 32'(bus.o_data), 32'(e));
    check({tag, "_v"}, 32'(bus.o_valid), 32'd1);
    bus.i_command = COM_NOP;
  endtask

  task automatic expect_yhf(input logic [W-1:0] y, input logic [W-1:0] h, input logic [7:0] f,
                            input string tag);
    exp_q.push_back(y);
    rd_check(COM_OUTPUTY, {tag, "_y"});
    exp_q.push_back(h);
    rd_check(COM_OUTPUTH, {tag, "_h"});
    exp_q.push_back(W'(f));
    rd_check(COM_OUTPUTF, {tag, "_f"});
  endtask

  // Counts busy cycles from the negedge after the COMPUTE edge; bounded.
  task automatic count_busy(output int n, input bit poke_a);
    n = 0;
    while (bus.o_busy && n < 100) begin
      n++;
      if (n == 3) begin
        bus.i_command = COM_OUTPUTY;
        #1;
        check("busy_rd_valid", 32'(bus.o_valid), 32'd0);
        check("busy_rd_data", 32'(bus.o_data), 32'd0);
        bus.i_command = COM_NOP;
      end
      if (poke_a && n == 5) begin
        bus.i_command = COM_LATCHA;
        bus.i_valid   = 1'b1;
        bus.i_data    = 16'h5555;
      end else begin
        bus.i_command = COM_NOP;
        bus.i_valid   = 1'b0;
        bus.i_data    = '0;
      end
      @(negedge clk);
    end
    bus.i_command = COM_NOP;
    bus.i_valid   = 1'b0;
  endtask

  initial begin
    int n;
    checks        = 0;
    failures      = 0;
    bus.i_command = COM_NOP;
    bus.i_valid   = 1'b0;
    bus.i_data    = '0;
    rst           = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    #1;
    check("rst_busy", 32'(bus.o_busy), 32'd0);
    check("rst_idle_data", 32'(bus.o_data), 32'd0);
    check("rst_idle_valid", 32'(bus.o_valid), 32'd0);
    expect_yhf(16'h0000, 16'h0000, 8'h00, "rst");

    run_op(ALU_ADD, 16'hFFFF, 16'h0001);
    check("add_busy", 32'(bus.o_busy), 32'd0);
    expect_yhf(16'h0000, 16'h0000, 8'h03, "add");

    wr(COM_LATCHF, 16'h0001);
    run_op(ALU_SBC, 16'h0005, 16'h0007);
    expect_yhf(16'hFFFE, 16'h0000, 8'h00, "sbc");

    run_op(ALU_ROL, 16'h8001, 16'h0000);
    expect_yhf(16'h8001, 16'h0000, 8'h00, "rol0");
    run_op(ALU_ROL, 16'h8001, 16'h0001);
    expect_yhf(16'h0003, 16'h0000, 8'h00, "rol1");

    run_op(ALU_CMP, 16'h0003, 16'h0005);
    expect_yhf(16'h0003, 16'h0000, 8'h10, "cmp_lt");

    run_op(ALU_XOR, 16'h00FF, 16'h0F0F);
    expect_yhf(16'h0FF0, 16'h0000, 8'h00, "xor");

    run_op(ALU_DEC, 16'h0000, 16'h0000);
    expect_yhf(16'hFFFF, 16'h0000, 8'h00, "dec0");

    run_op(op_e'(5'h1F), 16'h1111, 16'h2222);
    expect_yhf(16'h0000, 16'h0000, 8'h80, "undef");

`ifdef ARGON_ALU_MULDIV_EN
    run_op(ALU_MUL, 16'h1234, 16'h0100);
    check("mul_busy_start", 32'(bus.o_busy), 32'd1);
    count_busy(n, 1'b1);
    check("mul_busy_len", 32'(n), 32'd16);
    expect_yhf(16'h3400, 16'h0012, 8'h01, "mul");
    // rA must still be 0x1234 despite the LATCHA issued while busy.
    wr(COM_LATCHB, 16'h0000);
    wr(COM_LATCHOP, W'(ALU_ADD));
    wr(COM_COMPUTE, '0);
    expect_yhf(16'h1234, 16'h0012, 8'h00, "a_kept");

    run_op(ALU_DIVU, 16'd100, 16'd7);
    count_busy(n, 1'b0);
    check("div_busy_len", 32'(n), 32'd16);
    expect_yhf(16'd14, 16'd2, 8'h00, "div");

    run_op(ALU_DIVU, 16'h00AB, 16'h0000);
    check("div0_busy", 32'(bus.o_busy), 32'd0);
    expect_yhf(16'hFFFF, 16'h00AB, 8'h80, "div0");

    run_op(ALU_MUL, 16'h00FF, 16'h00FF);
    repeat (5) @(negedge clk);
    check("abort_busy_before", 32'(bus.o_busy), 32'd1);
    rst = 1'b1;
    #1;
    check("abort_busy", 32'(bus.o_busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("abort_stays_idle", 32'(bus.o_busy), 32'd0);
    expect_yhf(16'h0000, 16'h0000, 8'h00, "abort");
`else
    run_op(ALU_MUL, 16'h1234, 16'h0100);
    check("mul_off_busy", 32'(bus.o_busy), 32'd0);
    expect_yhf(16'h0000, 16'h0000, 8'h80, "mul_off");

    run_op(ALU_DIVU, 16'h00AB, 16'h0000);
    check("div_off_busy", 32'(bus.o_busy), 32'd0);
    expect_yhf(16'h0000, 16'h0000, 8'h80, "div_off");

    run_op(ALU_OR, 16'h1200, 16'h0034);
    expect_yhf(16'h1234, 16'h0000, 8'h00, "or");
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst2_busy", 32'(bus.o_busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    expect_yhf(16'h0000, 16'h0000, 8'h00, "rst2");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/argon_alu_mc.md
Name: argon_alu_mc

Overview:
Parametrised next-generation Argon ALU with a command-driven single-bus interface. Register file is rA, rB, rOp, rF, rY, plus a new high/remainder register rH. Single-cycle ops and flag semantics carry over from the existing ALU. Adds width/shift generalisation and multi-cycle unsigned MUL/DIV behind a busy handshake. Sits on the CPU datapath bus as a bus slave.

Parameters:
WIDTH, 16, datapath word width; must be ≥8 and a power of two.
SHW, $clog2(WIDTH), shift-amount width (derived; not overridden).

Ports:
i_Clk  in  1  clock
i_Reset  in  1  asynchronous active-high reset
i_command  in  4  bus command (COM_* in alu_pkg)
i_valid  in  1  command/data qualifier
i_data  in  WIDTH  bus write data
o_data  out  WIDTH  bus read data; 0 when not driving
o_valid  out  1  read data valid
o_busy  out  1  multi-cycle op in progress

Behaviour:
- Reset: one clock i_Clk; reset is asynchronous and active-high on i_Reset. rA/rB/rY/rH/rF/rOp/counter = 0, FSM = IDLE, o_busy = 0, o_valid = 0, o_data = 0. Reset mid-MUL/DIV aborts the operation; no partial result is kept.
- Write commands act at posedge only when i_valid=1 and FSM=IDLE: COM_LATCHA, COM_LATCHB, COM_LATCHF (rF <= i_data[7:0]), COM_LATCHOP (rOp <= i_data[4:0]), COM_COMPUTE. When busy they are silently dropped.
- Read commands are combinational and independent of i_valid: COM_OUTPUTY, COM_OUTPUTH, COM_OUTPUTF (zero-extended).
  - o_valid=1 only when FSM=IDLE.
  - While busy: o_valid=0, o_data=0.
- Flags (rF bits): F_CARRY=0, F_ZERO=1, F_EQUAL=2, F_GREATER=3, F_LESS=4, F_ERROR=7. Each COMPUTE rewrites all of rF.
- Single-cycle ops (ADD, ADC, SBC, CMP, INC, DEC, NAND, AND, OR, NOR, XOR, LSH, RSH, ROL, ROR):
  - rY/rF are updated at the COMPUTE edge and are readable the next cycle. rH is unchanged.
  - SBC = A + ~B + C_in; carry = no-borrow.
  - CMP leaves rY unchanged; it sets EQUAL/GREATER/LESS and ZERO(rY).
  - Shift amount = rB[SHW-1:0]. A rotate by 0 returns A.
  - ZERO is set for every op that writes rY.
- FSM: IDLE → MUL or DIV on COMPUTE with opcode ALU_MUL or ALU_DIVU. The counter runs WIDTH cycles, then the FSM returns to IDLE.
  - o_busy is high exactly WIDTH cycles, starting the cycle after the COMPUTE edge.
  - Results are written on the last busy edge.
- MUL: shift-add. {rH,rY} = rA*rB. CARRY = (rH≠0). ZERO = (full product = 0).
- DIVU: restoring division. rY = quotient, rH = remainder. ZERO = (quotient = 0).
- DIVU with rB=0: no busy phase, single cycle. rY = all ones, rH = rA, F_ERROR=1.
- Undefined opcode: rY = 0, rH unchanged, rF = only F_ERROR set.
- Operands are snapshotted at start, so rA/rB are stable during the op; latches are blocked anyway.

Optional Feature:
ARGON_ALU_MULDIV_EN. When defined: MUL/DIVU are implemented as described above. When undefined: ALU_MUL/ALU_DIVU are treated as undefined opcodes (F_ERROR), o_busy is tied 0, COM_OUTPUTH still reads rH (only ever 0 or reset value), and the FSM and sub-module are not instantiated.

Decomposition:
- alu_pkg holds the following shared definitions:
  - 5-bit opcode enum including ALU_MUL and ALU_DIVU.
  - F_* bit indices.
  - Command enum COM_* with new COM_OUTPUTH.
  - FSM state typedef (IDLE, MUL, DIV).
- One sub-module, argon_muldiv_seq (parametrised WIDTH): start/op/a/b in, busy/done/hi/lo out. It owns the iteration counter and the shift/subtract datapath.

Test Plan:
- WIDTH=16, ADD 0xFFFF+0x0001 → rY=0x0000, F_CARRY=1, F_ZERO=1, no busy.
- SBC 0x0005-0x0007 with C=1 → rY=0xFFFE, F_CARRY=0. ROL 0x8001 by 0 → 0x8001; by 1 → 0x0003.
- MUL 0x1234×0x0100 → o_busy high 16 cycles, then rY=0x3400, rH=0x0012, F_CARRY=1. OUTPUTY during busy → o_valid=0.
- DIVU 100/7 → rY=14, rH=2, 16 busy cycles. DIVU 0x00AB/0 → rY=0xFFFF, rH=0x00AB, F_ERROR=1, o_busy never asserted.
- LATCHA 0x5555 mid-MUL → ignored; after done rA is unchanged. Reset asserted at busy cycle 5 → all regs 0, o_busy=0 immediately.
- Build with ARGON_ALU_MULDIV_EN undefined: ALU_MUL → rF=0x80, rY=0, o_busy stays 0.
